// File: rtl/exec_sequencer_pkg.sv
// Shared constants for the execution sequencer: decoded opcode/group flag indices,
// stage bit positions and the one-hot state encoding built from them.
package exec_sequencer_pkg;

    localparam int OPCODE_COUNT = 12;
    localparam int GROUP_COUNT  = 6;

    // Bit positions inside the one-hot opcode_type vector
    localparam int TYPE_UNKNOWN = 0;
    localparam int TYPE_NOP     = 1;
    localparam int TYPE_ADD     = 2;
    localparam int TYPE_SUB     = 3;
    localparam int TYPE_MOV     = 4;
    localparam int TYPE_RJMP    = 5;
    localparam int TYPE_BRBS    = 6;
    localparam int TYPE_BRBC    = 7;
    localparam int TYPE_LD      = 8;
    localparam int TYPE_ST      = 9;
    localparam int TYPE_PUSH    = 10;
    localparam int TYPE_POP     = 11;

    // Bit positions inside the opcode_group flag vector (flags may combine)
    localparam int GROUP_ALU          = 0;
    localparam int GROUP_REGISTER     = 1;
    localparam int GROUP_CONTROL_FLOW = 2;
    localparam int GROUP_MEMORY       = 3;
    localparam int GROUP_LOAD         = 4;
    localparam int GROUP_STORE        = 5;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    // One-hot so the state register doubles as the stage output
    typedef enum logic [4:0] {
        ST_IF  = 5'(1 << STAGE_IF),
        ST_ID  = 5'(1 << STAGE_ID),
        ST_EX  = 5'(1 << STAGE_EX),
        ST_MEM = 5'(1 << STAGE_MEM),
        ST_WB  = 5'(1 << STAGE_WB)
    } state_t;

    function automatic logic signed [11:0] sext7(input logic [6:0] v);
        return $signed({{5{v[6]}}, v});
    endfunction

endpackage

// File: rtl/exec_sequencer_branch_eval.sv
// Combinational branch resolution: decides whether a control-flow op is taken
// and produces the signed PC displacement for it.
module branch_eval
    import exec_sequencer_pkg::*;
(
    input  logic               is_rjmp,
    input  logic               is_brbs,
    input  logic               is_brbc,
    input  logic [11:0]        imd,
    input  logic [2:0]         bit_idx,
    input  logic [7:0]         sreg,
    output logic               taken,
    output logic signed [11:0] offset
);

    always_comb begin
        taken  = 1'b0;
        offset = '0;
        if (is_rjmp) begin
            taken  = 1'b1;
            offset = $signed(imd);
        end else if (is_brbs) begin
            taken  = sreg[bit_idx];
            offset = sext7(imd[6:0]);
        end else if (is_brbc) begin
            taken  = !sreg[bit_idx];
            offset = sext7(imd[6:0]);
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: steps IF/ID/EX/MEM/WB and issues the
// single-cycle control strobes for each decoded instruction class.
module exec_sequencer
    import exec_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_COUNT-1:0] opcode_type,
    input  logic [GROUP_COUNT-1:0]  opcode_group,
    input  logic [11:0]             opcode_imd,
    input  logic [2:0]              opcode_bit,
    input  logic [7:0]              sreg,
    input  logic                    mem_ack,
    output logic [4:0]              stage,
    output logic                    ir_load,
    output logic                    pc_inc,
    output logic                    pc_load,
    output logic signed [11:0]      pc_offset,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    sp_inc,
    output logic                    sp_dec,
    output logic                    alu_en,
    output logic                    reg_we,
    output logic                    illegal
);

    state_t                  state, state_nxt;
    logic [OPCODE_COUNT-1:0] type_q;
    logic [GROUP_COUNT-1:0]  group_q;
    logic [11:0]             imd_q;
    logic [2:0]              bit_q;
    logic                    br_taken;
    logic signed [11:0]      br_offset;
    logic                    unused_type;

    assign unused_type = ^type_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IF;
            type_q  <= '0;
            group_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ID) begin
                type_q  <= opcode_type;
                group_q <= opcode_group;
            end
        end
    end

    // Operand fields follow the opcode capture but need no reset
    always_ff @(posedge clk) begin
        if (state == ST_ID) begin
            imd_q <= opcode_imd;
            bit_q <= opcode_bit;
        end
    end

    branch_eval u_branch_eval (
        .is_rjmp (type_q[TYPE_RJMP]),
        .is_brbs (type_q[TYPE_BRBS]),
        .is_brbc (type_q[TYPE_BRBC]),
        .imd     (imd_q),
        .bit_idx (bit_q),
        .sreg    (sreg),
        .taken   (br_taken),
        .offset  (br_offset)
    );

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_offset = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        alu_en    = 1'b0;
        reg_we    = 1'b0;
        illegal   = 1'b0;

        case (state)
            ST_IF: begin
                ir_load   = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = ST_ID;
            end
            ST_ID: begin
                if (opcode_type[TYPE_UNKNOWN]) begin
                    illegal   = 1'b1;
                    state_nxt = ST_IF;
                end else if (opcode_type[TYPE_NOP]) begin
                    state_nxt = ST_IF;
                end else begin
                    state_nxt = ST_EX;
                end
            end
            ST_EX: begin
                if (group_q[GROUP_CONTROL_FLOW]) begin
                    pc_load   = br_taken;
                    pc_offset = br_offset;
                    state_nxt = ST_IF;
                end else if (group_q[GROUP_MEMORY]) begin
                    sp_inc    = type_q[TYPE_POP];
                    state_nxt = ST_MEM;
                end else if (group_q[GROUP_ALU]) begin
                    alu_en    = 1'b1;
                    state_nxt = ST_WB;
                end else if (group_q[GROUP_REGISTER]) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_IF;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = group_q[GROUP_STORE];
                if (mem_ack) begin
                    sp_dec    = type_q[TYPE_PUSH];
                    state_nxt = group_q[GROUP_LOAD] ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                reg_we    = 1'b1;
                state_nxt = ST_IF;
            end
            default: state_nxt = ST_IF;
        endcase

        // Outputs are quiet while reset is held, whatever state is registered
        if (!rst_n) begin
            ir_load   = 1'b0;
            pc_inc    = 1'b0;
            pc_load   = 1'b0;
            pc_offset = '0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            sp_inc    = 1'b0;
            sp_dec    = 1'b0;
            alu_en    = 1'b0;
            reg_we    = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign stage = rst_n ? state : ST_IF;

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL declare ports clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-002 SHALL declare opcode_type input `OPCODE_COUNT, decoded instruction type, and opcode_group input `GROUP_COUNT, decoded group flags, both from defines.vh.
REQ-003 SHALL declare opcode_imd input 12, decoded immediate/offset; opcode_bit input 3, SREG bit index; sreg input 8, current status register.
REQ-004 SHALL declare mem_ack input 1, data-memory completion strobe.
REQ-005 SHALL declare stage output 5, one-hot {WB,MEM,EX,ID,IF}; ir_load output 1, latch instruction register.
REQ-006 SHALL declare pc_inc output 1, PC+1; pc_load output 1, PC <= PC+1+pc_offset; pc_offset output 12, signed offset.
REQ-007 SHALL declare mem_req output 1, mem_we output 1, sp_inc output 1, sp_dec output 1, alu_en output 1, reg_we output 1, illegal output 1 (one-cycle unknown-opcode pulse).

Function
REQ-008 SHALL implement FSM states IF, ID, EX, MEM, WB; one state per cycle unless stalled in MEM.
REQ-009 IF SHALL assert ir_load and pc_inc for exactly one cycle, then go to ID.
REQ-010 ID SHALL go to EX; if opcode_type is TYPE_UNKNOWN it SHALL pulse illegal and return to IF.
REQ-011 TYPE_NOP SHALL go ID->IF, no other strobes.
REQ-012 EX for GROUP_ALU SHALL assert alu_en, then go to WB.
REQ-013 EX for GROUP_REGISTER SHALL go to WB without alu_en.
REQ-014 EX for GROUP_CONTROL_FLOW SHALL evaluate taken and return to IF.
REQ-014a RJMP is always taken.
REQ-014b BRBS is taken iff sreg[opcode_bit]=1; BRBC iff sreg[opcode_bit]=0.
REQ-014c Taken SHALL assert pc_load for one cycle; not taken SHALL assert no PC strobe.
REQ-015 pc_offset SHALL be opcode_imd[11:0] for RJMP; sign-extended opcode_imd[6:0] for BRBS/BRBC; 0 otherwise.
REQ-016 EX for POP SHALL assert sp_inc (pre-increment), then go to MEM.
REQ-017 EX for other GROUP_MEMORY types SHALL go to MEM with no SP strobe.
REQ-018 MEM SHALL hold mem_req high until mem_ack is sampled high, with mem_we=1 for GROUP_STORE and 0 for GROUP_LOAD.
REQ-018a mem_req SHALL deassert on the cycle after ack.
REQ-019 On ack, PUSH SHALL assert sp_dec (post-decrement) in that same ack cycle.
REQ-020 On ack, GROUP_LOAD SHALL go to WB and GROUP_STORE SHALL go to IF.
REQ-021 WB SHALL assert reg_we for one cycle, then go to IF.
REQ-022 Every strobe SHALL be a single-cycle pulse; sp_inc and sp_dec SHALL never be asserted together.
REQ-023 mem_ack outside MEM SHALL be ignored.
REQ-024 opcode_type/opcode_group SHALL be sampled and held internally at ID exit; input changes in EX/MEM/WB SHALL have no effect.
REQ-025 An instruction SHALL take 2 cycles (NOP), 3 (control flow), 4 (ALU/register), 4+N (store), or 5+N (load/POP), where N is the number of ack wait cycles (N>=0).

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state IF, clear held opcode, and drive all strobes and pc_offset to 0.
REQ-026a stage SHALL read 5'b00001 during reset.
REQ-027 Reset in MEM SHALL drop mem_req on the next edge; an in-flight mem_ack SHALL then be ignored.
REQ-028 The first cycle after rst_n rises SHALL be IF, with ir_load=1.

Structure
REQ-029 State encodings and stage bit indices SHALL live in defines.vh alongside the TYPE_/GROUP_ constants.
REQ-030 Branch-condition evaluation (taken, pc_offset) SHALL be one combinational sub-module, branch_eval; the FSM stays in exec_sequencer.

Verification
REQ-031 Scenario ADD r16,r17 (0x0F01 decoded): stage sequence IF,ID,EX,WB; alu_en in EX; reg_we in WB; 4 cycles.
REQ-032 Scenario BRBS bit1, imd=0x7E, sreg=0x02: pc_load=1 in EX, pc_offset=0xFFE. With sreg=0x00: no pc_load, return to IF.
REQ-033 Scenario PUSH with mem_ack delayed 3 cycles: mem_req high 4 cycles, mem_we=1, sp_dec only in ack cycle; 7 cycles total.
REQ-034 Scenario POP, ack immediate: sp_inc in EX, mem_we=0, reg_we in WB; 5 cycles.
REQ-035 Scenario rst_n low during MEM wait: next cycle stage=00001 and mem_req=0; a late mem_ack causes no strobe.
REQ-036 Scenario unknown opcode: illegal pulses in ID; next state IF; no mem_req, reg_we or pc_load.
